// File: rtl/fifo_uart_tx.sv
// fifo_uart_tx: pops bytes from an 8-bit synchronous FIFO and serialises each as 8N1 on tx_o.
// Latency: first start-bit cycle is 3 cycles after the IDLE decision edge; 10*CLKS_PER_BIT+3 cycles per byte.
// Backpressure: pops only when tx_en_i=1 and fifo_empty_i=0 in IDLE; a started frame always completes.
// Ports:
//   clk, rst        - clock, asynchronous active-high reset
//   tx_en_i         - permits starting a new frame (sampled only in IDLE)
//   fifo_empty_i    - FIFO empty flag (sampled only in IDLE)
//   fifo_data_i     - FIFO read data, valid the cycle after a sampled pop
//   fifo_rd_en_o    - one-cycle pop pulse (FETCH)
//   tx_o            - UART line, idles high
//   busy_o          - high in every state except IDLE
//   done_o          - pulse on the last cycle of the stop bit
module fifo_uart_tx #(
  parameter int CLKS_PER_BIT = 16,
  parameter int CNT_W        = $clog2(CLKS_PER_BIT)
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tx_en_i,
  input  logic       fifo_empty_i,
  input  logic [7:0] fifo_data_i,
  output logic       fifo_rd_en_o,
  output logic       tx_o,
  output logic       busy_o,
  output logic       done_o
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FETCH = 3'd1,
    LOAD  = 3'd2,
    START = 3'd3,
    DATA  = 3'd4,
    STOP  = 3'd5
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CLKS_PER_BIT - 1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       bit_q, bit_d;
  logic [7:0]       sh_q, sh_d;
  logic             tx_q, tx_d;

  logic bit_end;
  assign bit_end = (cnt_q == CNT_MAX);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      sh_q    <= '0;
      tx_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      sh_q    <= sh_d;
      tx_q    <= tx_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    sh_d    = sh_q;
    case (state_q)
      IDLE: begin
        if (tx_en_i && !fifo_empty_i) begin
          state_d = FETCH;
        end
      end
      FETCH: begin
        state_d = LOAD;
      end
      LOAD: begin
        sh_d    = fifo_data_i;
        cnt_d   = '0;
        state_d = START;
      end
      START: begin
        if (bit_end) begin
          cnt_d   = '0;
          bit_d   = '0;
          state_d = DATA;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      DATA: begin
        if (bit_end) begin
          cnt_d = '0;
          sh_d  = {1'b0, sh_q[7:1]};
          if (bit_q == 3'd7) begin
            state_d = STOP;
          end else begin
            bit_d = bit_q + 3'd1;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      STOP: begin
        if (bit_end) begin
          cnt_d   = '0;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // The line level is registered from the next state so tx_o changes on the
  // same edge as the state and carries no path from any input.
  always_comb begin
    tx_d = 1'b1;
    case (state_d)
      START:   tx_d = 1'b0;
      DATA:    tx_d = sh_d[0];
      default: tx_d = 1'b1;
    endcase
  end

  assign tx_o         = tx_q;
  assign fifo_rd_en_o = (state_q == FETCH);
  assign busy_o       = (state_q != IDLE);
  assign done_o       = (state_q == STOP) && bit_end;

endmodule

// File: tb/tb_fifo_uart_tx.sv
module tb_fifo_uart_tx;

  localparam int CPB = 4;
  localparam int FRAME = 10 * CPB;

  logic       clk;
  logic       rst;
  logic       tx_en_i;
  logic       fifo_empty_i = 1'b1;
  logic [7:0] fifo_data_i  = 8'h00;
  logic       fifo_rd_en_o;
  logic       tx_o;
  logic       busy_o;
  logic       done_o;

  fifo_uart_tx #(.CLKS_PER_BIT(CPB)) dut (
    .clk          (clk),
    .rst          (rst),
    .tx_en_i      (tx_en_i),
    .fifo_empty_i (fifo_empty_i),
    .fifo_data_i  (fifo_data_i),
    .fifo_rd_en_o (fifo_rd_en_o),
    .tx_o         (tx_o),
    .busy_o       (busy_o),
    .done_o       (done_o)
  );

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int frames = 0;
  int exp_rd = 0;

  logic       wr_en  = 1'b0;
  logic [7:0] wr_dat = 8'h00;
  logic [7:0] fifo_mem[$];
  logic [7:0] exp_q[$];
  int         rd_times[$];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  // Cycle counter and behavioural synchronous FIFO (pop-then-push, registered flags).
  initial begin
    forever begin
      @(posedge clk);
      cyc = cyc + 1;
      if (fifo_rd_en_o === 1'b1) begin
        total++;
        if (fifo_mem.size() == 0) begin
          bad++;
          $display("FAIL underflow: pop with FIFO empty at cycle %0d", cyc);
        end else begin
          fifo_data_i <= fifo_mem.pop_front();
        end
      end
      if (wr_en) fifo_mem.push_back(wr_dat);
      fifo_empty_i <= (fifo_mem.size() == 0);
    end
  end

  // Pop monitor: timestamps each pop and checks it is a single-cycle pulse.
  initial begin
    logic prev_rd;
    prev_rd = 1'b0;
    forever begin
      @(negedge clk);
      if (rst === 1'b0 && fifo_rd_en_o === 1'b1) begin
        rd_times.push_back(cyc);
        total++;
        if (prev_rd) begin
          bad++;
          $display("FAIL rd_pulse_width: got=2+ cycles required=1 at cycle %0d", cyc);
        end
      end
      prev_rd = (fifo_rd_en_o === 1'b1);
    end
  end

  // Line monitor: on a start bit, takes the next expected byte from the
  // scoreboard and checks every cycle of the 10-bit frame plus done/busy.
  initial begin
    logic       in_frame;
    int         pos;
    logic [9:0] fbits;
    logic [9:0] got;
    logic       ferr;
    in_frame = 1'b0;
    pos = 0;
    fbits = '1;
    got = '0;
    ferr = 1'b0;
    forever begin
      @(negedge clk);
      if (rst !== 1'b0) begin
        in_frame = 1'b0;
      end else begin
        if (!in_frame && tx_o === 1'b0) begin
          in_frame = 1'b1;
          pos = 0;
          ferr = 1'b0;
          got = '0;
          if (exp_rd < exp_q.size()) begin
            fbits = {1'b1, exp_q[exp_rd], 1'b0};
            exp_rd++;
          end else begin
            fbits = '1;
            total++;
            bad++;
            $display("FAIL unexpected_frame: got=start bit required=idle at cycle %0d", cyc);
          end
        end
        if (in_frame) begin
          if (tx_o !== fbits[pos / CPB]) ferr = 1'b1;
          if (done_o !== (pos == FRAME - 1)) ferr = 1'b1;
          if (busy_o !== 1'b1) ferr = 1'b1;
          if (pos % CPB == CPB / 2) got[pos / CPB] = tx_o;
          pos++;
          if (pos == FRAME) begin
            in_frame = 1'b0;
            frames++;
            total++;
            if (ferr) begin
              bad++;
              $display("FAIL frame: got=%03h required=%03h (timing/done/busy checked per cycle)", got, fbits);
            end
          end
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic fifo_write(input logic [7:0] b);
    wr_dat = b;
    wr_en  = 1'b1;
    exp_q.push_back(b);
    @(negedge clk);
    wr_en  = 1'b0;
  endtask

  task automatic wait_idle(input int max);
    int n;
    n = 0;
    while (!(exp_rd == exp_q.size() && busy_o === 1'b0 && fifo_empty_i === 1'b1) && n < max) begin
      @(negedge clk);
      n++;
    end
    chk("wait_idle_timeout", 32'(n >= max), 32'd0);
  endtask

  task automatic wait_rd(input int max);
    int n;
    n = 0;
    while (fifo_rd_en_o !== 1'b1 && n < max) begin
      @(negedge clk);
      n++;
    end
    chk("wait_rd_timeout", 32'(n >= max), 32'd0);
  endtask

  initial begin
    int rd0;
    int f0;
    int n;
    logic seen;

    rst = 1'b0;
    tx_en_i = 1'b0;

    // Asynchronous reset between edges, then held.
    #7 rst = 1'b1;
    #1 chk("reset_async {tx,busy,rd,done}", {28'd0, tx_o, busy_o, fifo_rd_en_o, done_o}, 32'h8);
    repeat (3) begin
      @(negedge clk);
      chk("reset_hold {tx,busy,rd,done}", {28'd0, tx_o, busy_o, fifo_rd_en_o, done_o}, 32'h8);
    end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Single byte 0xA5.
    tx_en_i = 1'b1;
    rd0 = rd_times.size();
    f0 = frames;
    fifo_write(8'hA5);
    wait_idle(200);
    chk("single_reads", 32'(rd_times.size() - rd0), 32'd1);
    chk("single_frames", 32'(frames - f0), 32'd1);
    chk("single_tx_idle", {31'd0, tx_o}, 32'd1);

    // Burst 0x00..0x07: pops exactly 43 cycles apart.
    rd0 = rd_times.size();
    f0 = frames;
    for (int i = 0; i < 8; i++) fifo_write(8'(i));
    wait_idle(8 * 43 + 100);
    chk("burst_reads", 32'(rd_times.size() - rd0), 32'd8);
    chk("burst_frames", 32'(frames - f0), 32'd8);
    if (rd_times.size() - rd0 == 8) begin
      for (int k = 1; k < 8; k++)
        chk("burst_spacing", 32'(rd_times[rd0 + k] - rd_times[rd0 + k - 1]), 32'd43);
    end
    repeat (20) @(negedge clk);
    chk("burst_no_extra_reads", 32'(rd_times.size() - rd0), 32'd8);
    chk("burst_busy_low", {31'd0, busy_o}, 32'd0);

    // Empty FIFO with tx_en_i=1.
    rd0 = rd_times.size();
    seen = 1'b0;
    repeat (50) begin
      @(negedge clk);
      if (busy_o !== 1'b0) seen = 1'b1;
    end
    chk("empty_reads", 32'(rd_times.size() - rd0), 32'd0);
    chk("empty_busy", {31'd0, seen}, 32'd0);

    // Gating by tx_en_i.
    tx_en_i = 1'b0;
    rd0 = rd_times.size();
    f0 = frames;
    fifo_write(8'h11);
    fifo_write(8'h22);
    fifo_write(8'h33);
    seen = 1'b0;
    repeat (100) begin
      @(negedge clk);
      if (tx_o !== 1'b1 || busy_o !== 1'b0) seen = 1'b1;
    end
    chk("gate_hold_reads", 32'(rd_times.size() - rd0), 32'd0);
    chk("gate_hold_line", {31'd0, seen}, 32'd0);
    tx_en_i = 1'b1;
    @(negedge clk);
    chk("gate_fetch_next_cycle", {31'd0, fifo_rd_en_o}, 32'd1);
    repeat (10) @(negedge clk);
    tx_en_i = 1'b0;
    chk("gate_mid_data_busy", {31'd0, busy_o}, 32'd1);
    n = 0;
    while (busy_o !== 1'b0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("gate_frame_end_timeout", 32'(n >= 100), 32'd0);
    repeat (60) @(negedge clk);
    chk("gate_one_read", 32'(rd_times.size() - rd0), 32'd1);
    chk("gate_one_frame", 32'(frames - f0), 32'd1);
    tx_en_i = 1'b1;
    wait_idle(3 * 43 + 100);
    chk("gate_drain_frames", 32'(frames - f0), 32'd3);

    // Reset during bit 3 of 0x5A: 0x5A is dropped, 0xC3 follows in full.
    tx_en_i = 1'b0;
    fifo_write(8'h5A);
    fifo_write(8'hC3);
    rd0 = rd_times.size();
    f0 = frames;
    tx_en_i = 1'b1;
    wait_rd(20);
    repeat (18) @(negedge clk);
    chk("midreset_in_data_busy", {31'd0, busy_o}, 32'd1);
    #2 rst = 1'b1;
    #1 chk("midreset_async {tx,busy,rd,done}", {28'd0, tx_o, busy_o, fifo_rd_en_o, done_o}, 32'h8);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    wait_idle(200);
    chk("midreset_reads", 32'(rd_times.size() - rd0), 32'd2);
    chk("midreset_frames", 32'(frames - f0), 32'd1);

    // Randomised traffic: random bytes at random gaps.
    tx_en_i = 1'b1;
    f0 = frames;
    for (int i = 0; i < 6; i++) begin
      fifo_write(8'($urandom_range(0, 255)));
      repeat ($urandom_range(0, 70)) @(negedge clk);
    end
    wait_idle(6 * 43 + 200);
    chk("random_frames", 32'(frames - f0), 32'd6);

    chk("scoreboard_drained", 32'(exp_q.size() - exp_rd), 32'd0);
    chk("final_line_idle", {31'd0, tx_o}, 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fifo_uart_tx.md
# fifo_uart_tx

Read-side consumer for the 8-bit synchronous FIFO. It pops bytes whenever the FIFO reports non-empty and transmission is enabled. Each byte is serialised onto a UART line as 8N1 (1 start bit, 8 data bits LSB-first, 1 stop bit). It connects directly to the FIFO read port (rd_en / data / empty) and drives the chip-level TX pin.

## Interface
- `CLKS_PER_BIT`, default 16: clock cycles per UART bit; legal values ≥ 2.
- `CNT_W`, default `$clog2(CLKS_PER_BIT)`: width of the baud counter; derived, do not override.
- `clk`, input, 1: single clock; all logic is on the rising edge.
- `rst`, input, 1: reset, asynchronous and active-high.
- `tx_en_i`, input, 1: permits starting a new frame.
- `fifo_empty_i`, input, 1: FIFO empty flag.
- `fifo_data_i`, input, 8: FIFO read data; valid the cycle after a sampled read.
- `fifo_rd_en_o`, output, 1: FIFO pop request; registered, one-cycle pulse.
- `tx_o`, output, 1: UART serial line; idles high; registered.
- `busy_o`, output, 1: high in every state except IDLE.
- `done_o`, output, 1: one-cycle pulse on the last cycle of the stop bit.

## Operation
- States: IDLE, FETCH, LOAD, START, DATA, STOP.
- IDLE: if `tx_en_i` and `!fifo_empty_i` at a rising edge, go to FETCH. Otherwise stay.
- FETCH: `fifo_rd_en_o` = 1 for exactly this cycle. Next state is always LOAD.
- LOAD: capture `fifo_data_i` into the 8-bit shift register at the end of the cycle. Next state is START.
- START: `tx_o` = 0 for `CLKS_PER_BIT` cycles.
- DATA: 8 bits, LSB first. Each bit is held for `CLKS_PER_BIT` cycles. Shift right after each bit. A 3-bit bit index counts 0..7.
- STOP: `tx_o` = 1 for `CLKS_PER_BIT` cycles. `done_o` = 1 on the final cycle. Next state is IDLE.
- Baud counter: runs 0..`CLKS_PER_BIT`-1 in START, DATA and STOP. It resets to 0 on every bit boundary and on every state change.
- `fifo_empty_i` and `tx_en_i` are sampled only in IDLE.
  - Deasserting `tx_en_i` mid-frame does not abort the frame; the current frame completes.
  - The block never issues `fifo_rd_en_o` while `fifo_empty_i` = 1, so there is no FIFO underflow.
- Output values by state:
  - `tx_o` = 1 in IDLE, FETCH, LOAD and STOP.
  - `tx_o` = 0 in START.
  - `tx_o` = the shift register LSB in DATA.
- Reset value of every output: `tx_o` = 1, `fifo_rd_en_o` = 0, `busy_o` = 0, `done_o` = 0. State = IDLE; counters and shift register = 0.
- Reset mid-frame: `tx_o` returns to 1 immediately (asynchronously). The byte in flight is dropped and is not re-read.

## Timing
- Every output is a flop, or a decode of the state register alone. No output has a combinational path from any input.
- From the IDLE decision edge:
  - FETCH occupies cycle +1; the FIFO samples `fifo_rd_en_o` at the end of cycle +1.
  - LOAD occupies cycle +2; data is captured at the end of cycle +2.
  - The start bit begins in cycle +3.
- Frame length on `tx_o` is 10 × `CLKS_PER_BIT` cycles.
- Back-to-back throughput: a new FETCH can start 1 cycle after STOP ends, via one IDLE cycle. Period per byte = 10 × `CLKS_PER_BIT` + 3 cycles.
- `done_o` and the last stop-bit cycle coincide. `busy_o` falls on the following edge.

## Test plan
- Reset check (`CLKS_PER_BIT` = 4): assert `rst` asynchronously between edges. Expect `tx_o` = 1, `busy_o` = 0, `fifo_rd_en_o` = 0, `done_o` = 0 immediately, and they hold while reset is asserted.
- Single byte: FIFO holds 0xA5, `tx_en_i` = 1.
  - Expect exactly one `fifo_rd_en_o` pulse.
  - Expect `tx_o` sequence 0,1,0,1,0,0,1,0,1,1, each held 4 cycles (40 cycles in total).
  - Expect `done_o` high on cycle 40, then IDLE with `tx_o` = 1.
- Burst: write 0x00..0x07 into the FIFO (8 writes), `tx_en_i` = 1.
  - Expect 8 `fifo_rd_en_o` pulses spaced 43 cycles apart.
  - Expect decoded bytes 0x00..0x07 in order.
  - After the eighth frame: FIFO empty, no further reads, `busy_o` = 0.
- Gating: FIFO non-empty, `tx_en_i` = 0 for 100 cycles. Expect no reads and `tx_o` = 1. Raise `tx_en_i`; expect FETCH on the next cycle. Drop `tx_en_i` mid-DATA; expect the frame to complete and no new fetch.
- Empty FIFO: `tx_en_i` = 1 with the FIFO empty for 50 cycles. Expect `fifo_rd_en_o` never asserted and `busy_o` = 0.
- Reset mid-DATA: pulse `rst` during bit 3 of 0x5A. Expect `tx_o` = 1 at once and state IDLE. After release, the next FIFO byte (not 0x5A) is transmitted in full.
